// File: rtl/lc3b_types.sv
// ============================================================================
// Module      : lc3b_types (package)
// Description : LC-3b shared types plus scoreboard counter helpers.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_reg;

    localparam int SB_CNT_W = 2;

    typedef logic [SB_CNT_W-1:0] sb_cnt_t;

    // Saturation value of a pending-write counter of the given width
    function automatic int sb_cmax(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/scoreboard_regfile_sb_counter.sv
// ============================================================================
// Module      : sb_counter
// Description : Saturating up/down pending-write counter with sync clear.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             sat,
    output logic             zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_count <= '0;
        end else if (inc && !dec && !sat) begin
            r_count <= r_count + 1'b1;
        end else if (dec && !inc && !zero) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign count = r_count;
    assign sat   = (r_count == {CNT_W{1'b1}});
    assign zero  = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/scoreboard_regfile.sv
// ============================================================================
// Module      : scoreboard_regfile
// Description : Multi-read register file with pending-write scoreboard.
//               Optional write-through bypass: SCOREBOARD_BYPASS_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module scoreboard_regfile
    import lc3b_types::*;
#(
    parameter int WIDTH    = $bits(lc3b_word),
    parameter int NUM_REGS = 8,
    parameter int NUM_RD   = 2,
    parameter int CNT_W    = SB_CNT_W,
    localparam int AW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]       rd_busy,
    input  logic                    issue_valid,
    input  logic [AW-1:0]           issue_dest,
    output logic                    issue_ready,
    input  logic                    wb_valid,
    input  logic [AW-1:0]           wb_dest,
    input  logic [WIDTH-1:0]        wb_data,
    input  logic                    flush,
    output logic                    sb_err
);

    localparam int CMAX = sb_cmax(CNT_W);

    logic [WIDTH-1:0] r_regs [NUM_REGS];
    logic [CNT_W-1:0] w_cnt  [NUM_REGS];
    logic [NUM_REGS-1:0] w_sat;
    logic [NUM_REGS-1:0] w_zero;
    logic             r_sb_err;

    assign issue_ready = (w_cnt[issue_dest] != CNT_W'(CMAX));

    generate
        for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
            logic w_inc;
            logic w_dec;

            assign w_inc = issue_valid && issue_ready && (issue_dest == AW'(r));
            assign w_dec = wb_valid && (wb_dest == AW'(r)) && !w_zero[r];

            sb_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .reset (reset),
                .clr   (flush),
                .inc   (w_inc),
                .dec   (w_dec),
                .count (w_cnt[r]),
                .sat   (w_sat[r]),
                .zero  (w_zero[r])
            );
        end
    endgenerate

    // Writes are never blocked, even by flush or an underflowing counter
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_regs[r] <= '0;
            end
        end else if (wb_valid) begin
            r_regs[wb_dest] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sb_err <= 1'b0;
        end else if (wb_valid && w_zero[wb_dest]) begin
            r_sb_err <= 1'b1;
        end
    end

    assign sb_err = r_sb_err;

    generate
        for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
            logic [AW-1:0] w_addr;
            logic          w_hit;

            assign w_addr = rd_addr[i*AW +: AW];
            assign w_hit  = wb_valid && (wb_dest == w_addr);
`ifdef SCOREBOARD_BYPASS_EN
            assign rd_data[i*WIDTH +: WIDTH] = w_hit ? wb_data : r_regs[w_addr];
            // The retiring final write frees the register this very cycle
            assign rd_busy[i] = !w_zero[w_addr] &&
                                !(w_hit && (w_cnt[w_addr] == CNT_W'(1)));
`else
            assign rd_data[i*WIDTH +: WIDTH] = r_regs[w_addr];
            assign rd_busy[i] = !w_zero[w_addr] && !(w_hit && 1'b0);
`endif
        end
    endgenerate

    logic w_unused;
    assign w_unused = ^w_sat;

endmodule

`default_nettype wire

// File: tb/tb_scoreboard_regfile.sv
// ============================================================================
// Module      : tb_scoreboard_regfile
// Description : Directed self-checking bench for scoreboard_regfile.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_scoreboard_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data;
    logic [1:0]  rd_busy;
    logic        issue_valid;
    logic [2:0]  issue_dest;
    logic        issue_ready;
    logic        wb_valid;
    logic [2:0]  wb_dest;
    logic [15:0] wb_data;
    logic        flush;
    logic        sb_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    scoreboard_regfile dut (
        .clk         (clk),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .issue_valid (issue_valid),
        .issue_dest  (issue_dest),
        .issue_ready (issue_ready),
        .wb_valid    (wb_valid),
        .wb_dest     (wb_dest),
        .wb_data     (wb_data),
        .flush       (flush),
        .sb_err      (sb_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply current inputs at the next rising edge, then settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        wb_valid    = 1'b0;
        flush       = 1'b0;
        reset       = 1'b0;
    endtask

    task automatic rd(input logic [2:0] p1, input logic [2:0] p0);
        rd_addr = {p1, p0};
        #1;
    endtask

    task automatic issue(input logic [2:0] d);
        idle();
        issue_valid = 1'b1;
        issue_dest  = d;
        step();
        idle();
    endtask

    task automatic wb(input logic [2:0] d, input logic [15:0] v);
        idle();
        wb_valid = 1'b1;
        wb_dest  = d;
        wb_data  = v;
        step();
        idle();
    endtask

    initial begin
        reset = 1'b1; issue_valid = 1'b0; issue_dest = '0; wb_valid = 1'b0;
        wb_dest = '0; wb_data = '0; flush = 1'b0; rd_addr = '0;
        step();
        idle();
        rd(3'd0, 3'd3);
        check("reset_busy", 32'(rd_busy), 32'h0);
        check("reset_ready", 32'(issue_ready), 32'h1);
        check("reset_err", 32'(sb_err), 32'h0);
        check("reset_data", rd_data, 32'h0);

        // 1: issue then write R3, both ports read it
        issue(3'd3);
        rd(3'd3, 3'd3);
        check("t1_busy_pending", 32'(rd_busy), 32'h3);
        wb(3'd3, 16'h1234);
        rd(3'd0, 3'd3);
        check("t1_data", rd_data, 32'h0000_1234);
        check("t1_busy", 32'(rd_busy), 32'h0);

        // 2: two pending writes to R5
        issue(3'd5);
        issue(3'd5);
        rd(3'd5, 3'd5);
        check("t2_busy2", 32'(rd_busy), 32'h3);
        wb(3'd5, 16'hAAAA);
        check("t2_busy1", 32'(rd_busy), 32'h3);
        check("t2_data1", rd_data, 32'hAAAA_AAAA);
        wb(3'd5, 16'hBBBB);
        check("t2_busy0", 32'(rd_busy), 32'h0);
        check("t2_data2", rd_data, 32'hBBBB_BBBB);

        // 3: saturate R1, refused fourth issue
        issue(3'd1);
        issue(3'd1);
        issue_dest = 3'd1; #1;
        check("t3_ready_cnt2", 32'(issue_ready), 32'h1);
        issue(3'd1);
        issue_dest = 3'd1; #1;
        check("t3_ready_sat", 32'(issue_ready), 32'h0);
        issue(3'd1);
        rd(3'd5, 3'd1);
        wb(3'd1, 16'h0001);
        wb(3'd1, 16'h0002);
        check("t3_busy_after2", 32'(rd_busy), 32'h1);
        wb(3'd1, 16'h0003);
        check("t3_busy_after3", 32'(rd_busy), 32'h0);
        check("t3_err", 32'(sb_err), 32'h0);

        // 4: issue+wb same cycle on R2, then flush beats issue on R4
        issue(3'd2);
        issue_valid = 1'b1; issue_dest = 3'd2;
        wb_valid = 1'b1; wb_dest = 3'd2; wb_data = 16'h2222;
        step();
        idle();
        rd(3'd2, 3'd2);
        check("t4_same_cycle_busy", 32'(rd_busy), 32'h3);
        issue(3'd4);
        issue(3'd4);
        rd(3'd2, 3'd4);
        check("t4_busy_pre_flush", 32'(rd_busy), 32'h3);
        flush = 1'b1; issue_valid = 1'b1; issue_dest = 3'd4;
        step();
        idle();
        rd(3'd2, 3'd4);
        check("t4_flush_busy", 32'(rd_busy), 32'h0);
        issue_dest = 3'd4; #1;
        check("t4_flush_ready", 32'(issue_ready), 32'h1);
        check("t4_err", 32'(sb_err), 32'h0);

        // 5: underflow write to R6
        wb(3'd6, 16'h00FF);
        rd(3'd3, 3'd6);
        check("t5_data", rd_data, 32'h1234_00FF);
        check("t5_err", 32'(sb_err), 32'h1);
        check("t5_busy", 32'(rd_busy), 32'h0);
        step();
        check("t5_err_sticky", 32'(sb_err), 32'h1);
        reset = 1'b1; wb_valid = 1'b1; wb_dest = 3'd6; wb_data = 16'h5555;
        step();
        idle();
        check("t5_reset_err", 32'(sb_err), 32'h0);
        check("t5_reset_data", rd_data, 32'h0);

        // 6: same-cycle writeback and read of R7
        issue(3'd7);
        rd(3'd0, 3'd7);
        wb_valid = 1'b1; wb_dest = 3'd7; wb_data = 16'hCAFE;
        #1;
`ifdef SCOREBOARD_BYPASS_EN
        check("t6_bypass_data", rd_data, 32'h0000_CAFE);
        check("t6_bypass_busy", 32'(rd_busy), 32'h0);
`else
        check("t6_nobypass_data", rd_data, 32'h0);
        check("t6_nobypass_busy", 32'(rd_busy), 32'h1);
`endif
        step();
        idle();
        check("t6_next_data", rd_data, 32'h0000_CAFE);
        check("t6_next_busy", 32'(rd_busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
